gemm_sequencer: RTL
===================

GEMM_SEQUENCER -- requirements
Module: gemm_sequencer

Interface
REQ-001 SHALL expose parameters: NUM_ROW 4, array rows; NUM_COL 4, array cols; LOG2_SRAM_BANK_DEPTH 5, SRAM address width; CTRL_WIDTH 4, ctrl-state width; OPCODE_WIDTH 4; BUF_ID_WIDTH 2; MEM_LOC_WIDTH 10.
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
REQ-003 SHALL have ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- i_inst_valid  in  1  instruction present
- o_inst_ready  out  1  sequencer can accept
- i_opcode  in  OPCODE_WIDTH  LD=0010, ST=0011, GEMM=0100, DRAINSYS=0101
- i_buf_id  in  BUF_ID_WIDTH  0=left, 1=top, 2=down
- i_mem_loc  in  MEM_LOC_WIDTH  [4:0] start addr, [9:5] end addr
- o_ctrl_state  out  CTRL_WIDTH  to array: IDLE=0, STEADY=1, DRAIN=3
- o_top/left/down_sram_rd_start_addr, o_top/left/down_sram_rd_end_addr  out  LOG2_SRAM_BANK_DEPTH each  address windows
- o_down_rd_en  out  1  down-buffer read strobe
- o_down_rd_addr  out  LOG2_SRAM_BANK_DEPTH  down-buffer read address
- o_done  out  1  one-cycle pulse, operation finished
- o_err  out  1  one-cycle pulse, instruction rejected

Function
REQ-004 SHALL implement FSM states S_IDLE, S_STEADY, S_DRAIN, S_STORE; all outputs registered.
REQ-005 o_inst_ready SHALL be 1 exactly when state is S_IDLE; instruction accepted on clk edge with i_inst_valid & o_inst_ready.
REQ-006 LD: buf_id 0/1/2 latches mem_loc[4:0]/[9:5] into that buffer's start/end registers; visible next cycle; state stays S_IDLE; o_done pulses next cycle.
REQ-007 LD with buf_id 3 SHALL change no register and pulse o_err next cycle.
REQ-008 GEMM: if left_end < left_start, pulse o_err, stay S_IDLE; else enter S_STEADY next cycle for L = (left_end - left_start) + NUM_ROW + NUM_COL - 1 cycles, then S_IDLE.
REQ-009 DRAINSYS SHALL enter S_DRAIN for exactly NUM_ROW cycles, then S_IDLE.
REQ-010 ST: if down_end < down_start, pulse o_err; else enter S_STORE, assert o_down_rd_en for down_end - down_start + 1 consecutive cycles with o_down_rd_addr = down_start, down_start+1, ..., down_end, then S_IDLE.
REQ-011 o_ctrl_state SHALL be 1 in S_STEADY, 3 in S_DRAIN, 0 in S_IDLE and S_STORE.
REQ-012 o_done SHALL pulse one cycle on the cycle state re-enters S_IDLE after GEMM, DRAINSYS or ST, and as per REQ-006; never concurrent with o_err.
REQ-013 Undefined opcodes SHALL be consumed, pulse o_err, change nothing else.
REQ-014 o_down_rd_en SHALL be 0 outside S_STORE; o_down_rd_addr holds last value.
REQ-015 Cycle counter SHALL be wide enough for L at max address span (no overflow at start=0, end=31).
REQ-016 Start == end SHALL be legal: GEMM L = NUM_ROW+NUM_COL-1, ST one read.
REQ-017 i_inst_valid while not ready SHALL be ignored; instruction fields sampled only at acceptance.

Reset
REQ-018 On rst assertion, at any time including mid-operation, state SHALL go to S_IDLE immediately; o_ctrl_state, all address outputs, o_down_rd_en, o_down_rd_addr, o_done, o_err SHALL be 0; o_inst_ready SHALL be 1 after release.
REQ-019 First instruction SHALL be accepted on the first clk edge after rst deasserts.

Verification
REQ-020 LD buf 0, mem_loc {end=4,start=0}, then LD buf 1 same -> left and top windows 0..4, o_done pulses twice, o_ctrl_state 0.
REQ-021 After REQ-020, GEMM -> o_ctrl_state=1 for exactly 11 cycles, o_inst_ready 0 throughout, then 0 with single o_done.
REQ-022 DRAINSYS -> o_ctrl_state=3 for 4 cycles, then o_done; next DRAINSYS accepted only after.
REQ-023 LD buf 2 {end=5,start=2}, ST -> o_down_rd_en high 4 cycles, addresses 2,3,4,5; ST with end=1,start=3 -> o_err, no read.
REQ-024 rst asserted mid-GEMM (cycle 5) -> o_ctrl_state 0 and all windows 0 same cycle; no o_done; LD buf 3 and opcode 0111 -> o_err each, no register change.

Source files
------------

// File: rtl/gemm_sequencer.sv
// Instruction sequencer for a NUM_ROW x NUM_COL systolic GEMM array.
// It tracks the SRAM address windows and runs the compute, drain and store phases.
module gemm_sequencer #(
  parameter int NUM_ROW              = 4,
  parameter int NUM_COL              = 4,
  parameter int LOG2_SRAM_BANK_DEPTH = 5,
  parameter int CTRL_WIDTH           = 4,
  parameter int OPCODE_WIDTH         = 4,
  parameter int BUF_ID_WIDTH         = 2,
  parameter int MEM_LOC_WIDTH        = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_inst_valid,
  output logic                            o_inst_ready,
  input  logic [OPCODE_WIDTH-1:0]         i_opcode,
  input  logic [BUF_ID_WIDTH-1:0]         i_buf_id,
  input  logic [MEM_LOC_WIDTH-1:0]        i_mem_loc,
  output logic [CTRL_WIDTH-1:0]           o_ctrl_state,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_sram_rd_end_addr,
  output logic                            o_down_rd_en,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_rd_addr,
  output logic                            o_done,
  output logic                            o_err
);

  localparam int AW = LOG2_SRAM_BANK_DEPTH;
  // Longest phase is a full-span GEMM: (2**AW - 1) + NUM_ROW + NUM_COL - 1 cycles.
  localparam int CNT_W = $clog2((2**AW) + NUM_ROW + NUM_COL) + 1;

  localparam logic [OPCODE_WIDTH-1:0] OP_LD    = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_ST    = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_GEMM  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_DRAIN = OPCODE_WIDTH'(5);

  localparam logic [BUF_ID_WIDTH-1:0] BUF_LEFT = BUF_ID_WIDTH'(0);
  localparam logic [BUF_ID_WIDTH-1:0] BUF_TOP  = BUF_ID_WIDTH'(1);
  localparam logic [BUF_ID_WIDTH-1:0] BUF_DOWN = BUF_ID_WIDTH'(2);

  localparam logic [CTRL_WIDTH-1:0] CTRL_IDLE   = CTRL_WIDTH'(0);
  localparam logic [CTRL_WIDTH-1:0] CTRL_STEADY = CTRL_WIDTH'(1);
  localparam logic [CTRL_WIDTH-1:0] CTRL_DRAIN  = CTRL_WIDTH'(3);

  typedef enum logic [1:0] {S_IDLE, S_STEADY, S_DRAIN, S_STORE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     left_start_q, left_start_d, left_end_q, left_end_d;
  logic [AW-1:0]     top_start_q, top_start_d, top_end_q, top_end_d;
  logic [AW-1:0]     down_start_q, down_start_d, down_end_q, down_end_d;
  logic [CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic              done_q, done_d, err_q, err_d;
  logic              rd_en_q, rd_en_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;

  logic              accept_s;
  logic              ld_buf_ok_s;
  logic              gemm_ok_s;
  logic              st_ok_s;
  logic [AW-1:0]     loc_start_s, loc_end_s;

  assign accept_s    = i_inst_valid && (state_q == S_IDLE);
  assign loc_start_s = i_mem_loc[AW-1:0];
  assign loc_end_s   = i_mem_loc[2*AW-1:AW];
  assign ld_buf_ok_s = (i_buf_id == BUF_LEFT) || (i_buf_id == BUF_TOP) || (i_buf_id == BUF_DOWN);
  assign gemm_ok_s   = (left_end_q >= left_start_q);
  assign st_ok_s     = (down_end_q >= down_start_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      left_start_q <= '0;
      left_end_q   <= '0;
      top_start_q  <= '0;
      top_end_q    <= '0;
      down_start_q <= '0;
      down_end_q   <= '0;
      ctrl_q       <= CTRL_IDLE;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      left_start_q <= left_start_d;
      left_end_q   <= left_end_d;
      top_start_q  <= top_start_d;
      top_end_q    <= top_end_d;
      down_start_q <= down_start_d;
      down_end_q   <= down_end_d;
      ctrl_q       <= ctrl_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
    end
  end

  // Phase counters hold (cycles - 1); a phase ends on the edge where the counter reads zero.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    left_start_d = left_start_q;
    left_end_d   = left_end_q;
    top_start_d  = top_start_q;
    top_end_d    = top_end_q;
    down_start_d = down_start_q;
    down_end_d   = down_end_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          case (i_opcode)
            OP_LD: begin
              case (i_buf_id)
                BUF_LEFT: begin left_start_d = loc_start_s; left_end_d = loc_end_s; end
                BUF_TOP:  begin top_start_d  = loc_start_s; top_end_d  = loc_end_s; end
                BUF_DOWN: begin down_start_d = loc_start_s; down_end_d = loc_end_s; end
                default:  begin end
              endcase
            end
            OP_GEMM: begin
              if (gemm_ok_s) begin
                state_d = S_STEADY;
                cnt_d   = CNT_W'(left_end_q - left_start_q) + CNT_W'(NUM_ROW + NUM_COL - 2);
              end else begin
                state_d = S_IDLE;
              end
            end
            OP_DRAIN: begin
              state_d = S_DRAIN;
              cnt_d   = CNT_W'(NUM_ROW - 1);
            end
            OP_ST: begin
              if (st_ok_s) begin
                state_d = S_STORE;
                cnt_d   = CNT_W'(down_end_q - down_start_q);
              end else begin
                state_d = S_IDLE;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_STEADY, S_DRAIN, S_STORE: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered array-facing outputs and status pulses.
  always_comb begin
    ctrl_d    = CTRL_IDLE;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          case (i_opcode)
            OP_LD: begin
              if (ld_buf_ok_s) done_d = 1'b1;
              else             err_d  = 1'b1;
            end
            OP_GEMM: begin
              if (gemm_ok_s) ctrl_d = CTRL_STEADY;
              else           err_d  = 1'b1;
            end
            OP_DRAIN: ctrl_d = CTRL_DRAIN;
            OP_ST: begin
              if (st_ok_s) begin
                rd_en_d   = 1'b1;
                rd_addr_d = down_start_q;
              end else begin
                err_d = 1'b1;
              end
            end
            default: err_d = 1'b1;
          endcase
        end else begin
          done_d = 1'b0;
        end
      end
      S_STEADY: begin
        if (cnt_q == '0) done_d = 1'b1;
        else             ctrl_d = CTRL_STEADY;
      end
      S_DRAIN: begin
        if (cnt_q == '0) done_d = 1'b1;
        else             ctrl_d = CTRL_DRAIN;
      end
      S_STORE: begin
        if (cnt_q == '0) begin
          done_d = 1'b1;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      default: ctrl_d = CTRL_IDLE;
    endcase
  end

  assign o_inst_ready              = (state_q == S_IDLE);
  assign o_ctrl_state              = ctrl_q;
  assign o_left_sram_rd_start_addr = left_start_q;
  assign o_left_sram_rd_end_addr   = left_end_q;
  assign o_top_sram_rd_start_addr  = top_start_q;
  assign o_top_sram_rd_end_addr    = top_end_q;
  assign o_down_sram_rd_start_addr = down_start_q;
  assign o_down_sram_rd_end_addr   = down_end_q;
  assign o_down_rd_en              = rd_en_q;
  assign o_down_rd_addr            = rd_addr_q;
  assign o_done                    = done_q;
  assign o_err                     = err_q;

endmodule
